// File: rtl/sdi_pkg.sv
// Shared constants for the SDI channel-coding blocks: direction select and
// the G1(x) = x^9 + x^4 + 1 scrambler geometry.
package sdi_pkg;

  typedef enum logic {
    MODE_SCRAMBLE   = 1'b0,
    MODE_DESCRAMBLE = 1'b1
  } sdi_mode_e;

  localparam int unsigned G1_TAP_LO = 4;
  localparam int unsigned G1_TAP_HI = 9;
  localparam int unsigned SH_LEN    = 9;

endpackage

// File: rtl/sdi_scr_step.sv
// Combinational DATA_W-bit unroll of the G1 scrambler/descrambler with an
// optional NRZI stage (present when SDI_SCR_NRZI_EN is defined).
module sdi_scr_step
  import sdi_pkg::*;
#(
  parameter int unsigned DATA_W = 10,
  parameter sdi_mode_e   MODE   = MODE_SCRAMBLE
) (
  input  logic [DATA_W-1:0] word,
  input  logic [SH_LEN-1:0] sh,
`ifdef SDI_SCR_NRZI_EN
  input  logic              nz,
  output logic              nz_next,
`endif
  output logic [DATA_W-1:0] coded,
  output logic [SH_LEN-1:0] sh_next
);

  logic [SH_LEN-1:0] st;
  logic              s;
`ifdef SDI_SCR_NRZI_EN
  logic              line_nz;
`endif

  always_comb begin
    st    = sh;
    s     = 1'b0;
    coded = '0;
`ifdef SDI_SCR_NRZI_EN
    line_nz = nz;
`endif
    // Bit 0 is first on the wire, so the loop walks the serial order.
    for (int unsigned i = 0; i < DATA_W; i++) begin
      if (MODE == MODE_SCRAMBLE) begin
        s = word[i] ^ st[G1_TAP_LO-1] ^ st[G1_TAP_HI-1];
`ifdef SDI_SCR_NRZI_EN
        line_nz  = line_nz ^ s;
        coded[i] = line_nz;
`else
        coded[i] = s;
`endif
      end else begin
`ifdef SDI_SCR_NRZI_EN
        s       = word[i] ^ line_nz;
        line_nz = word[i];
`else
        s = word[i];
`endif
        coded[i] = s ^ st[G1_TAP_LO-1] ^ st[G1_TAP_HI-1];
      end
      st = {st[SH_LEN-2:0], s};
    end
    sh_next = st;
`ifdef SDI_SCR_NRZI_EN
    nz_next = line_nz;
`endif
  end

endmodule

// File: rtl/sdi_scrambler_core.sv
// SDI scrambler/descrambler core with valid/ready handshake and word counter.
// NRZI stage is built only when SDI_SCR_NRZI_EN is defined.
module sdi_scrambler_core
  import sdi_pkg::*;
#(
  parameter int unsigned DATA_W = 10,
  parameter int unsigned MODE   = 0,
  parameter int unsigned CNT_W  = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clear,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              bypass,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  word_count
);

  localparam sdi_mode_e MODE_E = (MODE == 1) ? MODE_DESCRAMBLE : MODE_SCRAMBLE;

  logic [SH_LEN-1:0] sh_q;
  logic [SH_LEN-1:0] sh_d;
  logic [DATA_W-1:0] coded;
  logic              accept;
`ifdef SDI_SCR_NRZI_EN
  logic              nz_q;
  logic              nz_d;
`endif

  assign in_ready = !clear && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;

  sdi_scr_step #(
    .DATA_W (DATA_W),
    .MODE   (MODE_E)
  ) u_step (
    .word    (in_data),
    .sh      (sh_q),
`ifdef SDI_SCR_NRZI_EN
    .nz      (nz_q),
    .nz_next (nz_d),
`endif
    .coded   (coded),
    .sh_next (sh_d)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sh_q       <= '0;
`ifdef SDI_SCR_NRZI_EN
      nz_q       <= 1'b0;
`endif
      out_data   <= '0;
      out_valid  <= 1'b0;
      word_count <= '0;
    end else if (clear) begin
      sh_q       <= '0;
`ifdef SDI_SCR_NRZI_EN
      nz_q       <= 1'b0;
`endif
      out_valid  <= 1'b0;
      word_count <= '0;
    end else if (accept) begin
      out_data  <= bypass ? in_data : coded;
      out_valid <= 1'b1;
      // Bypassed words leave the line history untouched.
      if (!bypass) begin
        sh_q <= sh_d;
`ifdef SDI_SCR_NRZI_EN
        nz_q <= nz_d;
`endif
      end
      if (word_count != '1) begin
        word_count <= word_count + 1'b1;
      end
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
